// File: rtl/vga_axil_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vga_axil_slave : AXI4-lite slave front end turning AXI transfers into
// single-cycle write/read strobes for vga_top.            Rev 1.0
// ---------------------------------------------------------------------------
module vga_axil_slave #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 15,
  parameter int RD_LATENCY       = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            s_axi_awvalid_i,
  output logic                            s_axi_awready_o,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_awaddr_i,
  input  logic                            s_axi_wvalid_i,
  output logic                            s_axi_wready_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]     s_axi_wdata_i,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb_i,
  output logic                            s_axi_bvalid_o,
  input  logic                            s_axi_bready_i,
  output logic [1:0]                      s_axi_bresp_o,
  input  logic                            s_axi_arvalid_i,
  output logic                            s_axi_arready_o,
  input  logic [C_AXI_ADDR_WIDTH-1:0]     s_axi_araddr_i,
  output logic                            s_axi_rvalid_o,
  input  logic                            s_axi_rready_i,
  output logic [C_AXI_DATA_WIDTH-1:0]     s_axi_rdata_o,
  output logic [1:0]                      s_axi_rresp_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_waddr_o,
  output logic [C_AXI_DATA_WIDTH-1:0]     axil_wdata_o,
  output logic [C_AXI_DATA_WIDTH/8-1:0]   axil_wstrb_o,
  output logic                            axil_wready_o,
  output logic [C_AXI_ADDR_WIDTH-1:0]     axil_raddr_o,
  output logic                            axil_rreq_o,
  input  logic [C_AXI_DATA_WIDTH-1:0]     axil_rdata_i
);

  localparam int STRB_W = C_AXI_DATA_WIDTH / 8;
  localparam logic [3:0] LAT_LAST = 4'(RD_LATENCY - 1);

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  logic                        w_wr_hs;
  logic                        bvalid_q;
  logic                        wstb_q;
  logic [C_AXI_ADDR_WIDTH-1:0] waddr_q;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]           wstrb_q;

  rstate_e                     rstate_q;
  logic [3:0]                  rcnt_q;
  logic [C_AXI_ADDR_WIDTH-1:0] raddr_q;
  logic                        rreq_q;
  logic                        rvalid_q;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_q;

  // Only joint AW+W is accepted, and never while a B response is pending.
  assign w_wr_hs         = s_axi_awvalid_i & s_axi_wvalid_i & ~bvalid_q & ~rst_i;
  assign s_axi_awready_o = w_wr_hs;
  assign s_axi_wready_o  = w_wr_hs;
  assign s_axi_bvalid_o  = bvalid_q;
  assign s_axi_bresp_o   = 2'b00;
  assign axil_waddr_o    = waddr_q;
  assign axil_wdata_o    = wdata_q;
  assign axil_wstrb_o    = wstrb_q;
  assign axil_wready_o   = wstb_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bvalid_q <= 1'b0;
      wstb_q   <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
    end else begin
      wstb_q <= w_wr_hs;
      if (w_wr_hs) begin
        waddr_q  <= s_axi_awaddr_i;
        wdata_q  <= s_axi_wdata_i;
        wstrb_q  <= s_axi_wstrb_i;
        bvalid_q <= 1'b1;
      end else if (bvalid_q && s_axi_bready_i) begin
        bvalid_q <= 1'b0;
      end
    end
  end

  assign s_axi_arready_o = (rstate_q == R_IDLE) & ~rst_i;
  assign s_axi_rvalid_o  = rvalid_q;
  assign s_axi_rdata_o   = rdata_q;
  assign s_axi_rresp_o   = 2'b00;
  assign axil_raddr_o    = raddr_q;
  assign axil_rreq_o     = rreq_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rstate_q <= R_IDLE;
      rcnt_q   <= 4'd0;
      raddr_q  <= '0;
      rreq_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rreq_q <= 1'b0;
      case (rstate_q)
        R_IDLE: begin
          if (s_axi_arvalid_i) begin
            raddr_q  <= s_axi_araddr_i;
            rreq_q   <= 1'b1;
            rcnt_q   <= 4'd0;
            rstate_q <= R_WAIT;
          end
        end
        // The first counted edge is the one that ends the rreq cycle.
        R_WAIT: begin
          if (rcnt_q == LAT_LAST) begin
            rdata_q  <= axil_rdata_i;
            rvalid_q <= 1'b1;
            rcnt_q   <= 4'd0;
            rstate_q <= R_RESP;
          end else begin
            rcnt_q <= rcnt_q + 4'd1;
          end
        end
        R_RESP: begin
          if (s_axi_rready_i) begin
            rvalid_q <= 1'b0;
            rstate_q <= R_IDLE;
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vga_axil_slave.sv
`default_nettype none
// Directed bench for vga_axil_slave: stimulus driven 1ns after the rising
// edge, outputs checked 2ns after the rising edge.
module tb_vga_axil_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [14:0] awaddr, araddr, waddr, raddr;
  logic [31:0] wdata, rdata, axwdata, axrdata;
  logic [3:0]  wstrb, axwstrb;
  logic [1:0]  bresp, rresp;
  logic        axwready, rreq;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vga_axil_slave #(
    .C_AXI_DATA_WIDTH(32),
    .C_AXI_ADDR_WIDTH(15),
    .RD_LATENCY(2)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .s_axi_awvalid_i(awvalid), .s_axi_awready_o(awready), .s_axi_awaddr_i(awaddr),
    .s_axi_wvalid_i(wvalid), .s_axi_wready_o(wready), .s_axi_wdata_i(wdata),
    .s_axi_wstrb_i(wstrb), .s_axi_bvalid_o(bvalid), .s_axi_bready_i(bready),
    .s_axi_bresp_o(bresp), .s_axi_arvalid_i(arvalid), .s_axi_arready_o(arready),
    .s_axi_araddr_i(araddr), .s_axi_rvalid_o(rvalid), .s_axi_rready_i(rready),
    .s_axi_rdata_o(rdata), .s_axi_rresp_o(rresp),
    .axil_waddr_o(waddr), .axil_wdata_o(axwdata), .axil_wstrb_o(axwstrb),
    .axil_wready_o(axwready), .axil_raddr_o(raddr), .axil_rreq_o(rreq),
    .axil_rdata_i(axrdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    awaddr = 15'h0010; wdata = 32'h11111111; wstrb = 4'h3; araddr = 15'h0020;
    bready = 1'b0; rready = 1'b0; axrdata = 32'h0;

    // T1: reset held with valids asserted, then simultaneous AW+W+AR
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq("t1_rst_awready", awready, 0);
      check_eq("t1_rst_arready", arready, 0);
      check_eq("t1_rst_bvalid", bvalid, 0);
      check_eq("t1_rst_rvalid", rvalid, 0);
      check_eq("t1_rst_wstb", axwready, 0);
      check_eq("t1_rst_rreq", rreq, 0);
      check_eq("t1_rst_waddr", waddr, 0);
    end
    cyc(); rst = 1'b0; #1;
    check_eq("t1_rel_awready", awready, 1);
    check_eq("t1_rel_wready", wready, 1);
    check_eq("t1_rel_arready", arready, 1);
    cyc(); awvalid = 0; wvalid = 0; arvalid = 0; axrdata = 32'hDEAD0001; #1;
    check_eq("t1_wstb", axwready, 1);
    check_eq("t1_waddr", waddr, 32'h0010);
    check_eq("t1_wdata", axwdata, 32'h11111111);
    check_eq("t1_wstrb", axwstrb, 4'h3);
    check_eq("t1_bvalid", bvalid, 1);
    check_eq("t1_rreq", rreq, 1);
    check_eq("t1_raddr", raddr, 32'h0020);
    cyc(); axrdata = 32'hCAFE0002; #1;
    check_eq("t1_wstb_off", axwready, 0);
    check_eq("t1_rreq_off", rreq, 0);
    check_eq("t1_rvalid_early", rvalid, 0);
    check_eq("t1_bvalid_hold", bvalid, 1);
    bready = 1'b1;
    cyc(); axrdata = 32'h0; #1;
    check_eq("t1_bvalid_clr", bvalid, 0);
    check_eq("t1_rvalid", rvalid, 1);
    check_eq("t1_rdata", rdata, 32'hCAFE0002);
    rready = 1'b1;
    cyc(); #1;
    check_eq("t1_rvalid_clr", rvalid, 0);
    check_eq("t1_arready_back", arready, 1);
    rready = 1'b0;

    // T2: single write with bready high
    cyc(); awvalid = 1; wvalid = 1; awaddr = 15'h2004; wdata = 32'h0000000A; wstrb = 4'hF; #1;
    check_eq("t2_awready", awready, 1);
    cyc(); awvalid = 0; wvalid = 0; #1;
    check_eq("t2_wstb", axwready, 1);
    check_eq("t2_waddr", waddr, 32'h2004);
    check_eq("t2_wdata", axwdata, 32'h0000000A);
    check_eq("t2_wstrb", axwstrb, 4'hF);
    check_eq("t2_bvalid", bvalid, 1);
    check_eq("t2_bresp", bresp, 0);
    cyc(); #1;
    check_eq("t2_wstb_off", axwready, 0);
    check_eq("t2_waddr_hold1", waddr, 32'h2004);
    check_eq("t2_bvalid_clr", bvalid, 0);
    cyc(); #1;
    check_eq("t2_waddr_hold2", waddr, 32'h2004);

    // T3: AW ahead of W
    awvalid = 1; awaddr = 15'h3008; wdata = 32'h0000000B;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_eq("t3_lone_aw_awready", awready, 0);
      check_eq("t3_lone_aw_wstb", axwready, 0);
      cyc();
    end
    wvalid = 1; #1;
    check_eq("t3_joint_awready", awready, 1);
    cyc(); awvalid = 0; wvalid = 0; #1;
    check_eq("t3_wstb", axwready, 1);
    check_eq("t3_waddr", waddr, 32'h3008);
    check_eq("t3_bvalid", bvalid, 1);
    cyc(); #1;
    check_eq("t3_wstb_off", axwready, 0);
    check_eq("t3_bvalid_clr", bvalid, 0);
    cyc(); #1;
    check_eq("t3_single_b", bvalid, 0);

    // T4: B back-pressure then back-to-back writes
    bready = 0; awvalid = 1; wvalid = 1; awaddr = 15'h0100; wdata = 32'h1; #1;
    check_eq("t4_acc1", awready, 1);
    cyc(); awaddr = 15'h0104; wdata = 32'h2; #1;
    check_eq("t4_wstb1", axwready, 1);
    check_eq("t4_blocked", awready, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(); #1;
      check_eq("t4_bvalid_hold", bvalid, 1);
      check_eq("t4_blocked_loop", awready, 0);
      check_eq("t4_no_pulse", axwready, 0);
      check_eq("t4_waddr_hold", waddr, 32'h0100);
    end
    cyc(); bready = 1; #1;
    check_eq("t4_bvalid_hs", bvalid, 1);
    check_eq("t4_blocked_hs", awready, 0);
    cyc(); #1;
    check_eq("t4_acc2", awready, 1);
    cyc(); awaddr = 15'h0108; wdata = 32'h3; #1;
    check_eq("t4_wstb2", axwready, 1);
    check_eq("t4_waddr2", waddr, 32'h0104);
    cyc(); #1;
    check_eq("t4_gap", axwready, 0);
    check_eq("t4_acc3", awready, 1);
    cyc(); awvalid = 0; wvalid = 0; #1;
    check_eq("t4_wstb3", axwready, 1);
    check_eq("t4_waddr3", waddr, 32'h0108);
    cyc(); #1;
    check_eq("t4_wstb3_off", axwready, 0);

    // T5: read with RD_LATENCY=2
    arvalid = 1; araddr = 15'h4000; #1;
    check_eq("t5_arready", arready, 1);
    cyc(); arvalid = 0; axrdata = 32'h11112222; #1;
    check_eq("t5_rreq", rreq, 1);
    check_eq("t5_raddr", raddr, 32'h4000);
    check_eq("t5_arready_busy", arready, 0);
    check_eq("t5_rvalid_m1", rvalid, 0);
    cyc(); axrdata = 32'h41424344; #1;
    check_eq("t5_rreq_off", rreq, 0);
    check_eq("t5_rvalid_m2", rvalid, 0);
    cyc(); axrdata = 32'h99999999; #1;
    check_eq("t5_rvalid_m3", rvalid, 1);
    check_eq("t5_rdata", rdata, 32'h41424344);
    check_eq("t5_rresp", rresp, 0);
    rready = 1;
    cyc(); #1;
    check_eq("t5_rvalid_clr", rvalid, 0);
    check_eq("t5_arready_back", arready, 1);
    rready = 0;

    // T6: R back-pressure while a write goes through
    arvalid = 1; araddr = 15'h4100;
    cyc(); arvalid = 0; axrdata = 32'h0;
    cyc(); axrdata = 32'h55667788;
    cyc(); axrdata = 32'h0; bready = 1; #1;
    check_eq("t6_rvalid", rvalid, 1);
    awvalid = 1; wvalid = 1; awaddr = 15'h0200; wdata = 32'h77;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) begin awvalid = 0; wvalid = 0; end
      #1;
      check_eq("t6_rvalid_hold", rvalid, 1);
      check_eq("t6_rdata_hold", rdata, 32'h55667788);
      check_eq("t6_arready_busy", arready, 0);
      if (i == 0) begin
        check_eq("t6_wstb", axwready, 1);
        check_eq("t6_waddr", waddr, 32'h0200);
        check_eq("t6_wdata", axwdata, 32'h77);
      end else begin
        check_eq("t6_bvalid_done", bvalid, 0);
      end
    end
    rready = 1;
    cyc(); #1;
    check_eq("t6_rvalid_clr", rvalid, 0);
    check_eq("t6_arready_back", arready, 1);
    rready = 0;

    // T7: reset during the latency wait drops the read
    arvalid = 1; araddr = 15'h0044;
    cyc(); arvalid = 0; rst = 1; axrdata = 32'hABCDABCD;
    cyc(); rst = 0; #1;
    check_eq("t7_rvalid", rvalid, 0);
    check_eq("t7_raddr_rst", raddr, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      check_eq("t7_no_rvalid", rvalid, 0);
      check_eq("t7_no_rreq", rreq, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
